// File: rtl/ptb2_pkg.sv
// Shared constants for the quadratic-solver request arbiter: FSM state codes,
// core result codes and default datapath widths.
package ptb2_pkg;

    localparam int COEF_W_DEF  = 5;
    localparam int ROOT_W_DEF  = 4;
    localparam int TIMEOUT_DEF = 64;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_WAIT_DONE = 3'd2;
    localparam logic [2:0] S_READ1     = 3'd3;
    localparam logic [2:0] S_CAP1      = 3'd4;
    localparam logic [2:0] S_READ2     = 3'd5;
    localparam logic [2:0] S_CAP2      = 3'd6;
    localparam logic [2:0] S_RESP      = 3'd7;

    localparam logic [1:0] RES_NONE   = 2'b00;
    localparam logic [1:0] RES_DOUBLE = 2'b01;
    localparam logic [1:0] RES_TWO    = 2'b10;
    localparam logic [1:0] RES_DEGEN  = 2'b11;

endpackage

// File: rtl/ptb2_rr_arb.sv
// Two-way round-robin grant: on a tie the requester not granted last wins.
module ptb2_rr_arb (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       accept,
    output logic [1:0] grant
);

    // High when requester 1 was granted most recently; reset value lets requester 0 win the first tie.
    logic last_reg;

    always_comb begin
        grant = valid;
        if (valid == 2'b11) begin
            grant = last_reg ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_reg <= 1'b1;
        end else if (accept) begin
            last_reg <= grant[1];
        end
    end

endmodule

// File: rtl/ptb2_arbiter.sv
// Shares one quadratic-solver core between two requesters: arbitrates, runs the
// core start/done/read sequence, and returns roots or a timeout error.
module ptb2_arbiter
    import ptb2_pkg::*;
#(
    parameter int COEF_W  = COEF_W_DEF,
    parameter int ROOT_W  = ROOT_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    input  logic [1:0]            i_req_valid,
    output logic [1:0]            o_req_ready,
    input  logic [2*COEF_W-1:0]   i_req_a,
    input  logic [2*COEF_W-1:0]   i_req_b,
    input  logic [2*COEF_W-1:0]   i_req_c,
    output logic [1:0]            o_rsp_valid,
    input  logic [1:0]            i_rsp_ready,
    output logic [1:0]            o_rsp_result,
    output logic [ROOT_W-1:0]     o_rsp_x1,
    output logic [ROOT_W-1:0]     o_rsp_x2,
    output logic                  o_rsp_err,
    output logic [COEF_W-1:0]     o_core_A,
    output logic [COEF_W-1:0]     o_core_B,
    output logic [COEF_W-1:0]     o_core_C,
    output logic                  o_core_start,
    output logic                  o_core_read_en,
    input  logic                  i_core_done,
    input  logic [1:0]            i_core_result,
    input  logic [ROOT_W-1:0]     i_core_data_out
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [2:0]        state_reg;
    logic              gnt_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [COEF_W-1:0] core_a_reg, core_b_reg, core_c_reg;
    logic [1:0]        result_reg;
    logic [ROOT_W-1:0] x1_reg, x2_reg;
    logic              err_reg;

    logic [1:0]        grant;
    logic              accept;
    logic [COEF_W-1:0] a_slice [2];
    logic [COEF_W-1:0] b_slice [2];
    logic [COEF_W-1:0] c_slice [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_slice
            assign a_slice[gi] = i_req_a[gi*COEF_W +: COEF_W];
            assign b_slice[gi] = i_req_b[gi*COEF_W +: COEF_W];
            assign c_slice[gi] = i_req_c[gi*COEF_W +: COEF_W];
        end
    endgenerate

    ptb2_rr_arb u_rr_arb (
        .clk    (i_Clk),
        .rst    (i_Rst),
        .valid  (i_req_valid),
        .accept (accept),
        .grant  (grant)
    );

    // Ready is masked during reset so every output reads zero while i_Rst is high.
    assign o_req_ready    = (state_reg == S_IDLE && !i_Rst) ? grant : 2'b00;
    assign accept         = |(i_req_valid & o_req_ready);
    assign o_core_start   = (state_reg == S_START);
    assign o_core_read_en = (state_reg == S_READ1) || (state_reg == S_READ2);
    assign o_rsp_valid    = (state_reg == S_RESP) ? (gnt_reg ? 2'b10 : 2'b01) : 2'b00;
    assign o_rsp_result   = result_reg;
    assign o_rsp_x1       = x1_reg;
    assign o_rsp_x2       = x2_reg;
    assign o_rsp_err      = err_reg;
    assign o_core_A       = core_a_reg;
    assign o_core_B       = core_b_reg;
    assign o_core_C       = core_c_reg;

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_reg  <= S_IDLE;
            gnt_reg    <= 1'b0;
            cnt_reg    <= '0;
            core_a_reg <= '0;
            core_b_reg <= '0;
            core_c_reg <= '0;
            result_reg <= RES_NONE;
            x1_reg     <= '0;
            x2_reg     <= '0;
            err_reg    <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        gnt_reg    <= grant[1];
                        core_a_reg <= a_slice[grant[1]];
                        core_b_reg <= b_slice[grant[1]];
                        core_c_reg <= c_slice[grant[1]];
                        result_reg <= RES_NONE;
                        x1_reg     <= '0;
                        x2_reg     <= '0;
                        err_reg    <= 1'b0;
                        state_reg  <= S_START;
                    end
                end
                S_START: begin
                    cnt_reg   <= '0;
                    state_reg <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    // A done arriving on the final counted cycle still wins over the timeout.
                    if (i_core_done) begin
                        result_reg <= i_core_result;
                        if (i_core_result == RES_TWO || i_core_result == RES_DOUBLE) begin
                            state_reg <= S_READ1;
                        end else begin
                            state_reg <= S_RESP;
                        end
                    end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
                        err_reg    <= 1'b1;
                        result_reg <= RES_NONE;
                        state_reg  <= S_RESP;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                S_READ1: state_reg <= S_CAP1;
                S_CAP1: begin
                    x1_reg <= i_core_data_out;
                    if (result_reg == RES_TWO) begin
                        state_reg <= S_READ2;
                    end else begin
                        x2_reg    <= i_core_data_out;
                        state_reg <= S_RESP;
                    end
                end
                S_READ2: state_reg <= S_CAP2;
                S_CAP2: begin
                    x2_reg    <= i_core_data_out;
                    state_reg <= S_RESP;
                end
                S_RESP: begin
                    if (i_rsp_ready[gnt_reg]) begin
                        core_a_reg <= '0;
                        core_b_reg <= '0;
                        core_c_reg <= '0;
                        state_reg  <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule
